crc_arb: RTL and testbench
==========================

CRC_ARB -- requirements
Module: crc_arb

Interface
REQ-001 SHALL provide parameter RD_LAT, default 1, meaning cycles from crc_Sel assertion to valid crc_data_rd (legal 1..4).
REQ-002 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL provide ports req0/req1  input  1  requester 0/1 transaction request, level.
REQ-005 SHALL provide ports rw0/rw1  input  1  1=write, 0=read.
REQ-006 SHALL provide ports len0/len1  input  2  read burst length in words; 0 treated as 1.
REQ-007 SHALL provide ports addr0/addr1  input  32  start byte address.
REQ-008 SHALL provide ports wdata0/wdata1  input  32  write data.
REQ-009 SHALL provide ports gnt0/gnt1  output  1  one-cycle pulse, request accepted.
REQ-010 SHALL provide ports rvld0/rvld1  output  1  one-cycle pulse per returned read word.
REQ-011 SHALL provide port rdata  output  32  shared read data, meaningful only with rvld0/rvld1.
REQ-012 SHALL provide ports done0/done1  output  1  one-cycle pulse, transaction complete.
REQ-013 SHALL provide port busy  output  1  high whenever FSM is not IDLE.
REQ-014 SHALL provide ports crc_addr  output  32, crc_data_wr  output  32, crc_RW  output  1, crc_Sel  output  1, crc_data_rd  input  32: CRC register port.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-016 In IDLE with any req high, SHALL select one requester, latch its rw/len/addr/wdata, and enter ACCESS next cycle.
REQ-017 Arbitration SHALL be round-robin: single requester always wins; on tie the requester not granted last wins; after reset req0 wins first tie.
REQ-018 In each ACCESS cycle SHALL drive crc_Sel=1, crc_RW=latched rw, crc_addr=current beat address, crc_data_wr=latched wdata.
REQ-019 gnt of the selected requester SHALL pulse in the first ACCESS cycle of a transaction only.
REQ-020 Writes SHALL be single-word regardless of len: ACCESS -> DONE -> IDLE.
REQ-021 Reads: ACCESS -> WAIT for RD_LAT cycles; crc_data_rd SHALL be sampled in the last WAIT cycle.
REQ-022 If read beats remain, SHALL return to ACCESS with address +4; rdata/rvld for the sampled beat SHALL appear in that ACCESS cycle.
REQ-023 After the last read beat, SHALL enter DONE; rdata/rvld for the last beat and done SHALL be asserted together in DONE.
REQ-024 DONE SHALL last one cycle then return to IDLE; no arbitration in DONE.
REQ-025 Address increment SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-026 Outside ACCESS, crc_Sel=0 and crc_RW=0; crc_addr and crc_data_wr SHALL hold last values.
REQ-027 Changes on req/rw/len/addr/wdata after acceptance SHALL be ignored until the transaction completes.
REQ-028 A req still high in IDLE after its done SHALL be treated as a new request.

Reset
REQ-029 rst low SHALL immediately force IDLE, RR pointer to favour req0, and all outputs (gnt, rvld, done, busy, crc_Sel, crc_RW, crc_addr, crc_data_wr, rdata) to 0.
REQ-030 A transaction interrupted by reset SHALL be abandoned; no gnt/rvld/done for it after rst release.

Verification
REQ-031 req0 write, addr0=0x10, wdata0=0xDEADBEEF at cycle 0 -> cycle 1: gnt0, crc_Sel=1, crc_RW=1, crc_addr=0x10, crc_data_wr=0xDEADBEEF; cycle 2: done0; cycle 3: busy=0.
REQ-032 req1 read, len1=3, addr1=0x20, RD_LAT=1, model data=addr^0xA5A5A5A5 -> crc_Sel pulses at addr 0x20/0x24/0x28; three rvld1 with matching rdata; done1 with the third.
REQ-033 req0 and req1 both held high, single writes, after reset -> grant order gnt0, gnt1, gnt0, gnt1.
REQ-034 read len=2, addr=0xFFFFFFFC -> beat addresses 0xFFFFFFFC then 0x00000000.
REQ-035 RD_LAT=3, single read accepted at cycle 0 -> Sel at cycle 1, sampling at cycle 4, rvld+done at cycle 5.
REQ-036 rst low during WAIT -> same cycle crc_Sel=0, busy=0, no rvld/done; after release next tie granted to req0.

Source files
------------

// File: rtl/crc_arb.sv
// Two-requester round-robin arbiter in front of a single CRC register port.
// Reads are bursts of up to 3 words with a fixed RD_LAT read latency; writes are always one word.
module crc_arb #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [1:0]  len0,
    input  logic [1:0]  len1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvld0,
    output logic        rvld1,
    output logic [31:0] rdata,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic [31:0] crc_addr,
    output logic [31:0] crc_data_wr,
    output logic        crc_RW,
    output logic        crc_Sel,
    input  logic [31:0] crc_data_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rw_q, rw_d;
    logic [1:0]  beats_q, beats_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        fav1_q, fav1_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        rvld0_q, rvld0_d, rvld1_q, rvld1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        busy_q, busy_d;
    logic        sel_q, sel_d;
    logic        crc_rw_q, crc_rw_d;
    logic [31:0] crc_addr_q, crc_addr_d;
    logic [31:0] crc_wdata_q, crc_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick;
    logic [1:0]  len_sel;

    // Outputs are computed for the state being entered so that every output is a flop.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rw_d        = rw_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        fav1_d      = fav1_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvld0_d     = 1'b0;
        rvld1_d     = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        sel_d       = 1'b0;
        crc_rw_d    = 1'b0;
        crc_addr_d  = crc_addr_q;
        crc_wdata_d = crc_wdata_q;
        rdata_d     = rdata_q;
        pick        = req1 & (~req0 | fav1_q);
        len_sel     = pick ? len1 : len0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d     = pick;
                    fav1_d      = ~pick;
                    rw_d        = pick ? rw1 : rw0;
                    beats_d     = (len_sel == 2'd0) ? 2'd1 : len_sel;
                    crc_addr_d  = pick ? addr1 : addr0;
                    crc_wdata_d = pick ? wdata1 : wdata0;
                    gnt0_d      = ~pick;
                    gnt1_d      = pick;
                    sel_d       = 1'b1;
                    crc_rw_d    = rw_d;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (rw_q) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = crc_data_rd;
                    rvld0_d = ~owner_q;
                    rvld1_d = owner_q;
                    if (beats_q > 2'd1) begin
                        beats_d    = beats_q - 2'd1;
                        crc_addr_d = crc_addr_q + 32'd4;
                        sel_d      = 1'b1;
                        state_d    = ACCESS;
                    end else begin
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rw_q        <= 1'b0;
            beats_q     <= 2'd0;
            cnt_q       <= 2'd0;
            fav1_q      <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvld0_q     <= 1'b0;
            rvld1_q     <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            sel_q       <= 1'b0;
            crc_rw_q    <= 1'b0;
            crc_addr_q  <= 32'd0;
            crc_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rw_q        <= rw_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            fav1_q      <= fav1_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvld0_q     <= rvld0_d;
            rvld1_q     <= rvld1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
            crc_rw_q    <= crc_rw_d;
            crc_addr_q  <= crc_addr_d;
            crc_wdata_q <= crc_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvld0       = rvld0_q;
    assign rvld1       = rvld1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign crc_addr    = crc_addr_q;
    assign crc_data_wr = crc_wdata_q;
    assign crc_RW      = crc_rw_q;
    assign crc_Sel     = sel_q;

endmodule

// File: tb/tb_crc_arb.sv
// Bench for crc_arb: two instances (RD_LAT=1 and RD_LAT=3) share stimulus and are checked every
// cycle against a transaction-timeline model, plus directed vectors and corner-case sequences.
module tb_crc_arb;

    logic        clk;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [1:0]  len0, len1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        gnt0_o [2];
    logic        gnt1_o [2];
    logic        rvld0_o [2];
    logic        rvld1_o [2];
    logic        done0_o [2];
    logic        done1_o [2];
    logic        busy_o [2];
    logic        sel_o [2];
    logic        rw_o [2];
    logic [31:0] rdata_o [2];
    logic [31:0] caddr_o [2];
    logic [31:0] cwd_o [2];
    logic [31:0] crd_i [2];

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        crc_arb #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
            .len0(len0), .len1(len1), .addr0(addr0), .addr1(addr1),
            .wdata0(wdata0), .wdata1(wdata1),
            .gnt0(gnt0_o[g]), .gnt1(gnt1_o[g]),
            .rvld0(rvld0_o[g]), .rvld1(rvld1_o[g]),
            .rdata(rdata_o[g]),
            .done0(done0_o[g]), .done1(done1_o[g]),
            .busy(busy_o[g]),
            .crc_addr(caddr_o[g]), .crc_data_wr(cwd_o[g]),
            .crc_RW(rw_o[g]), .crc_Sel(sel_o[g]),
            .crc_data_rd(crd_i[g])
        );
        // CRC register model: read data is a fixed function of the address being presented.
        assign crd_i[g] = caddr_o[g] ^ 32'hA5A5A5A5;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is a timeline measured in cycles from its first ACCESS.
    // A read of n words with latency L occupies period p=L+1 per word; word b is presented at
    // offset b*p and returned at (b+1)*p; done coincides with the last return.
    typedef struct {
        logic        active;
        int          off;
        int          tlen;
        logic        owner;
        logic        rw;
        int          n;
        logic [31:0] a;
        logic        fav1;
        logic [31:0] last_addr;
        logic [31:0] last_wd;
        logic [31:0] last_rd;
    } mstate_t;

    mstate_t     m [2];
    int          lat [2] = '{1, 3};
    logic [8:0]  e_ctl [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_wd [2];
    logic [31:0] e_rd [2];

    task automatic model_reset(input int i);
        m[i] = '{default: 0};
        e_ctl[i] = '0;
        e_addr[i] = '0;
        e_wd[i] = '0;
        e_rd[i] = '0;
    endtask

    // ctl bit order: {gnt0, gnt1, rvld0, rvld1, done0, done1, busy, sel, rw}
    task automatic model_step(input int i);
        int p, o;
        logic w;
        logic [8:0] c;
        p = lat[i] + 1;
        c = '0;
        if (m[i].active) begin
            m[i].off = m[i].off + 1;
            if (m[i].off >= m[i].tlen) m[i].active = 1'b0;
        end else if (req0 || req1) begin
            w = (req0 && req1) ? m[i].fav1 : req1;
            m[i].fav1 = !w;
            m[i].owner = w;
            m[i].rw = w ? rw1 : rw0;
            m[i].n = int'(w ? len1 : len0);
            if (m[i].n == 0) m[i].n = 1;
            m[i].a = w ? addr1 : addr0;
            m[i].last_wd = w ? wdata1 : wdata0;
            m[i].off = 0;
            m[i].tlen = m[i].rw ? 2 : m[i].n * p + 1;
            m[i].active = 1'b1;
        end
        if (m[i].active) begin
            o = m[i].off;
            c[2] = 1'b1;
            if (o == 0) c[m[i].owner ? 7 : 8] = 1'b1;
            if (m[i].rw) begin
                if (o == 0) begin
                    c[1] = 1'b1;
                    c[0] = 1'b1;
                    m[i].last_addr = m[i].a;
                end else begin
                    c[m[i].owner ? 3 : 4] = 1'b1;
                end
            end else begin
                if (o % p == 0 && o < m[i].n * p) begin
                    c[1] = 1'b1;
                    m[i].last_addr = m[i].a + 32'(4 * (o / p));
                end
                if (o > 0 && o % p == 0) begin
                    c[m[i].owner ? 5 : 6] = 1'b1;
                    m[i].last_rd = (m[i].a + 32'(4 * (o / p - 1))) ^ 32'hA5A5A5A5;
                end
                if (o == m[i].n * p) c[m[i].owner ? 3 : 4] = 1'b1;
            end
        end
        e_ctl[i] = c;
        e_addr[i] = m[i].last_addr;
        e_wd[i] = m[i].last_wd;
        e_rd[i] = m[i].last_rd;
    endtask

    // Cycle-by-cycle scoreboard for both instances.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst) model_reset(i);
                else model_step(i);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("ctl_dut%0d", i),
                    32'({gnt0_o[i], gnt1_o[i], rvld0_o[i], rvld1_o[i], done0_o[i], done1_o[i],
                         busy_o[i], sel_o[i], rw_o[i]}), 32'(e_ctl[i]));
                checkOutput($sformatf("crc_addr_dut%0d", i), caddr_o[i], e_addr[i]);
                checkOutput($sformatf("crc_data_wr_dut%0d", i), cwd_o[i], e_wd[i]);
                checkOutput($sformatf("rdata_dut%0d", i), rdata_o[i], e_rd[i]);
            end
        end
    end

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [1:0]  l0, l1;
        logic [31:0] a0, a1, d0, d1;
        logic        exp_owner;
        logic        exp_rw;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        int          exp_cycles;
        int          exp_beats;
    } vec_t;

    vec_t tbl [5];

    task automatic applyStimulus(input vec_t v);
        req0 = v.r0; req1 = v.r1; rw0 = v.w0; rw1 = v.w1;
        len0 = v.l0; len1 = v.l1; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1;
    endtask

    task automatic scramble_idle();
        req0 = 1'b0; req1 = 1'b0;
        rw0 = 1'($urandom); rw1 = 1'($urandom);
        len0 = 2'($urandom); len1 = 2'($urandom);
        addr0 = $urandom; addr1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
    endtask

    // Returns at a falling edge during an IDLE cycle of both instances.
    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy_o[0] && !busy_o[1]) break;
        end
        checkOutput("idle_reached", 32'({busy_o[0], busy_o[1]}), 32'd0);
    endtask

    initial begin
        logic [3:0] seq;
        int ng, cyc, beats;
        logic own;

        rst = 1'b0;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; len0 = 0; len1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        tbl[0] = '{1, 0, 1, 0, 2'd0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0,
                   1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 0};
        tbl[1] = '{0, 1, 0, 0, 2'd0, 2'd3, 32'h0, 32'h20, 32'h0, 32'h1111,
                   1'b1, 1'b0, 32'h20, 32'h1111, 6, 3};
        tbl[2] = '{1, 0, 0, 1, 2'd0, 2'd2, 32'h100, 32'h0, 32'h2222, 32'h0,
                   1'b0, 1'b0, 32'h100, 32'h2222, 2, 1};
        tbl[3] = '{1, 1, 1, 0, 2'd1, 2'd2, 32'h300, 32'hFFFFFFFC, 32'h3333, 32'h4444,
                   1'b1, 1'b0, 32'hFFFFFFFC, 32'h4444, 4, 2};
        tbl[4] = '{1, 1, 1, 1, 2'd3, 2'd3, 32'h500, 32'h600, 32'h5555, 32'h6666,
                   1'b0, 1'b1, 32'h500, 32'h5555, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(tbl[v]);
            own = tbl[v].exp_owner;
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_first_ctl", v),
                32'({gnt0_o[0], gnt1_o[0], sel_o[0], rw_o[0]}),
                32'({~own, own, 1'b1, tbl[v].exp_rw}));
            checkOutput($sformatf("vec%0d_first_addr", v), caddr_o[0], tbl[v].exp_addr);
            checkOutput($sformatf("vec%0d_first_wd", v), cwd_o[0], tbl[v].exp_wd);
            @(negedge clk);
            scramble_idle();
            cyc = -1;
            beats = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (own ? rvld1_o[0] : rvld0_o[0]) beats++;
                if (own ? done1_o[0] : done0_o[0]) begin
                    cyc = k;
                    break;
                end
            end
            checkOutput($sformatf("vec%0d_cycles_to_done", v), 32'(cyc), 32'(tbl[v].exp_cycles));
            checkOutput($sformatf("vec%0d_read_beats", v), 32'(beats), 32'(tbl[v].exp_beats));
            wait_idle();
        end

        // RD_LAT=3 instance: select, three wait cycles, then data and done together.
        wait_idle();
        req0 = 1; req1 = 0; rw0 = 0; len0 = 2'd1; addr0 = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("lat3_cycle%0d", k),
                32'({sel_o[1], rvld0_o[1], done0_o[1]}),
                (k == 1) ? 32'h4 : (k == 5) ? 32'h3 : 32'h0);
            if (k == 1) begin
                @(negedge clk);
                req0 = 0;
            end
        end
        checkOutput("lat3_rdata", rdata_o[1], 32'h40 ^ 32'hA5A5A5A5);

        // Reset in the middle of a read wait, then a tie must go to requester 0 first.
        wait_idle();
        req0 = 1; rw0 = 0; len0 = 2'd1; addr0 = 32'h80;
        @(posedge clk);
        @(negedge clk);
        req0 = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_in_wait_ctl",
            32'({sel_o[0], busy_o[0], rvld0_o[0], done0_o[0], sel_o[1], busy_o[1]}), 32'd0);
        checkOutput("reset_in_wait_addr", caddr_o[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        rst = 1'b1;
        seq = 4'b1111;
        ng = 0;
        for (int k = 0; k < 30 && ng < 4; k++) begin
            @(posedge clk); #1;
            if (gnt0_o[0]) begin seq[3 - ng] = 1'b0; ng++; end
            else if (gnt1_o[0]) begin seq[3 - ng] = 1'b1; ng++; end
        end
        checkOutput("rr_grant_order", 32'(seq), 32'h5);
        @(negedge clk);
        req0 = 0; req1 = 0;
        wait_idle();

        // Random traffic, checked entirely by the scoreboard.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            len0 = 2'($urandom); len1 = 2'($urandom);
            addr0 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : {$urandom} & 32'hFFFF_FFFC;
            addr1 = {$urandom} & 32'hFFFF_FFFC;
            wdata0 = $urandom; wdata1 = $urandom;
        end
        req0 = 0; req1 = 0;
        wait_idle();
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
